byte_serializer: RTL and testbench

BYTE_SERIALIZER -- requirements
Module: byte_serializer

---
 rtl/byte_serializer.sv | 118 +++++++++++
 tb/tb_byte_serializer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_serializer.sv
// Byte FIFO feeding an 8-bit parallel-to-serial shifter that advances on the en bit-rate strobe.
// Back-to-back bytes are emitted without a gap cycle; state and bit count are visible on debug ports.
module byte_serializer #(
  parameter int   DEPTH     = 4,
  parameter logic IDLE_BIT  = 1'b0,
  parameter bit   MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       en,
  output logic                       dout,
  output logic                       dout_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       o_dbg_state,
  output logic [3:0]                 o_dbg_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [7:0]    r_shreg;
  logic          r_dout;
  logic          r_dout_valid;

  logic          w_push;
  logic          w_load;
  logic [7:0]    w_head;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on the registered level, so a full FIFO refuses a
  // push even when the shifter pops in the same cycle.
  assign in_ready = rst_n && (r_level < DEPTH_L);
  assign w_push   = in_valid && in_ready;
  assign w_head   = r_mem[r_rd_ptr];

  // A new byte is loaded from idle, or straight after the 8th bit so bytes abut.
  assign w_load = en && (r_level != '0) &&
                  ((r_state == S_IDLE) || (r_cnt == 4'd8));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_load) begin
        r_level <= r_level + 1'b1;
      end else if (!w_push && w_load) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_shreg      <= 8'd0;
      r_dout       <= IDLE_BIT;
      r_dout_valid <= 1'b0;
    end else if (en) begin
      if (w_load) begin
        r_state      <= S_SHIFT;
        r_cnt        <= 4'd1;
        r_dout_valid <= 1'b1;
        if (MSB_FIRST) begin
          r_dout  <= w_head[7];
          r_shreg <= {w_head[6:0], 1'b0};
        end else begin
          r_dout  <= w_head[0];
          r_shreg <= {1'b0, w_head[7:1]};
        end
      end else if ((r_state == S_SHIFT) && (r_cnt != 4'd8)) begin
        r_cnt <= r_cnt + 4'd1;
        if (MSB_FIRST) begin
          r_dout  <= r_shreg[7];
          r_shreg <= {r_shreg[6:0], 1'b0};
        end else begin
          r_dout  <= r_shreg[0];
          r_shreg <= {1'b0, r_shreg[7:1]};
        end
      end else begin
        r_state      <= S_IDLE;
        r_dout       <= IDLE_BIT;
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign level       = r_level;
  assign busy        = (r_state == S_SHIFT) || (r_level != '0);
  assign o_dbg_state = r_state;
  assign o_dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: MSB-first and LSB-first instances share one stimulus stream and are
// checked every cycle against a queue-based reference model plus a byte-level scoreboard.
module tb_byte_serializer;

  localparam int   DEPTH    = 4;
  localparam int   LW       = $clog2(DEPTH) + 1;
  localparam logic IDLE_BIT = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          en;

  logic          in_ready_m, dout_m, dout_valid_m, busy_m, state_m;
  logic [LW-1:0] level_m;
  logic [3:0]    cnt_m;
  logic          in_ready_l, dout_l, dout_valid_l, busy_l, state_l;
  logic [LW-1:0] level_l;
  logic [3:0]    cnt_l;

  byte_serializer #(.DEPTH(DEPTH), .IDLE_BIT(IDLE_BIT), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .en(en), .dout(dout_m), .dout_valid(dout_valid_m),
    .busy(busy_m), .level(level_m), .o_dbg_state(state_m), .o_dbg_cnt(cnt_m)
  );

  byte_serializer #(.DEPTH(DEPTH), .IDLE_BIT(IDLE_BIT), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .en(en), .dout(dout_l), .dout_valid(dout_valid_l),
    .busy(busy_l), .level(level_l), .o_dbg_state(state_l), .o_dbg_cnt(cnt_l)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO as a queue, current byte plus index of the bit on the wire.
  logic [7:0] m_q[$];
  bit         m_act = 1'b0;
  logic [7:0] m_byte = 8'd0;
  int         m_pos = 0;

  // Scoreboard: accepted bytes in order, rebuilt from the serial streams.
  logic [7:0] exp_q[$];
  int         nbits = 0;
  logic [7:0] acc_m = 8'd0;
  logic [7:0] acc_l = 8'd0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  pre;
    bit  ready;
    if (!rst_n) begin
      m_q.delete();
      exp_q.delete();
      m_act = 1'b0;
      m_pos = 0;
      nbits = 0;
      return;
    end
    pre   = m_q.size();
    ready = (pre < DEPTH);
    if (en) begin
      if (m_act && m_pos < 7) begin
        m_pos++;
      end else if (pre > 0) begin
        m_byte = m_q.pop_front();
        m_pos  = 0;
        m_act  = 1'b1;
      end else begin
        m_act = 1'b0;
      end
    end
    if (in_valid && ready) begin
      m_q.push_back(in_data);
      exp_q.push_back(in_data);
    end
  endtask

  task automatic check_all();
    logic       e_m, e_l, e_rdy, e_busy;
    logic [7:0] e_byte;
    e_m    = m_act ? m_byte[7 - m_pos] : IDLE_BIT;
    e_l    = m_act ? m_byte[m_pos]     : IDLE_BIT;
    e_rdy  = rst_n && (m_q.size() < DEPTH);
    e_busy = m_act || (m_q.size() != 0);
    chk("m_dout",       16'(dout_m),       16'(e_m));
    chk("l_dout",       16'(dout_l),       16'(e_l));
    chk("m_dout_valid", 16'(dout_valid_m), 16'(m_act));
    chk("l_dout_valid", 16'(dout_valid_l), 16'(m_act));
    chk("m_level",      16'(level_m),      16'(m_q.size()));
    chk("l_level",      16'(level_l),      16'(m_q.size()));
    chk("m_in_ready",   16'(in_ready_m),   16'(e_rdy));
    chk("l_in_ready",   16'(in_ready_l),   16'(e_rdy));
    chk("m_busy",       16'(busy_m),       16'(e_busy));
    chk("l_busy",       16'(busy_l),       16'(e_busy));
    chk("m_state",      16'(state_m),      16'(m_act));
    chk("l_state",      16'(state_l),      16'(m_act));
    if (m_act) begin
      chk("m_cnt", 16'(cnt_m), 16'(m_pos + 1));
      chk("l_cnt", 16'(cnt_l), 16'(m_pos + 1));
    end
    // A fresh bit is on the wire after every en=1 edge while valid.
    if (rst_n && en && dout_valid_m) begin
      acc_m = {acc_m[6:0], dout_m};
      acc_l = {dout_l, acc_l[7:1]};
      nbits++;
      if (nbits == 8) begin
        nbits = 0;
        chk("sb_byte_expected", 16'(exp_q.size() != 0), 16'd1);
        if (exp_q.size() != 0) begin
          e_byte = exp_q.pop_front();
          chk("sb_msb_byte", 16'(acc_m), 16'(e_byte));
          chk("sb_lsb_byte", 16'(acc_l), 16'(e_byte));
        end
      end
    end
  endtask

  // Driver: apply inputs, clock once, advance model, check at negedge.
  task automatic cyc(input logic r, input logic v, input logic e, input logic [7:0] d);
    rst_n    = r;
    in_valid = v;
    en       = e;
    in_data  = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_idle(input int n, input logic e);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, e, 8'h00);
  endtask

  logic [7:0] en_pat [13] = '{1,1,1,1,0,0,1,1,1,1,1,1,1};

  initial begin
    // Reset
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 8'h3C);
    chk("reset_cnt_m", 16'(cnt_m), 16'd0);
    chk("reset_cnt_l", 16'(cnt_l), 16'd0);

    // Single byte 0xB5 into idle block
    cyc(1'b1, 1'b1, 1'b1, 8'hB5);
    run_idle(11, 1'b1);

    // Back-to-back 0x0D, 0x0D
    cyc(1'b1, 1'b1, 1'b1, 8'h0D);
    cyc(1'b1, 1'b1, 1'b1, 8'h0D);
    run_idle(20, 1'b1);

    // Overfill with en=0: fifth byte refused
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 8'hA1 + 8'(i));
    chk("full_level", 16'(level_m), 16'(DEPTH));
    chk("full_ready", 16'(in_ready_m), 16'd0);
    run_idle(40, 1'b1);

    // 0xA5 with en stalls mid-byte
    cyc(1'b1, 1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 13; i++) cyc(1'b1, 1'b0, en_pat[i][0], 8'h00);
    run_idle(3, 1'b1);

    // Reset after 3 bits of 0xFF with two bytes queued
    cyc(1'b1, 1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b1, 1'b1, 8'h11);
    cyc(1'b1, 1'b1, 1'b1, 8'h22);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("abort_dout",  16'(dout_m),       16'(IDLE_BIT));
    chk("abort_valid", 16'(dout_valid_m), 16'd0);
    chk("abort_level", 16'(level_m),      16'd0);
    run_idle(12, 1'b1);

    // 0x0B: LSB-first instance must send 1,1,0,1,0,0,0,0
    cyc(1'b1, 1'b1, 1'b1, 8'h0B);
    run_idle(10, 1'b1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 149) != 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 3) != 0), 8'($urandom));
    end

    // Drain and confirm every accepted byte came out
    run_idle(60, 1'b1);
    chk("drain_exp_q", 16'(exp_q.size()), 16'd0);
    chk("drain_nbits", 16'(nbits), 16'd0);
    chk("drain_busy",  16'(busy_m), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
